// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: funct encodings, field widths,
// FSM state type and the funct payload struct carried from requester to ALU.
package alu_pkg;

    localparam int unsigned NREQ     = 2;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned F3_ALU_W = 4;
    localparam int unsigned F7_W     = 7;

    // funct3 encodings understood by the ALU
    localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU    = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR     = 3'b100;
    localparam logic [F3_W-1:0] F3_SRL_SRA = 3'b101;
    localparam logic [F3_W-1:0] F3_OR      = 3'b110;
    localparam logic [F3_W-1:0] F3_AND     = 3'b111;

    // funct7 encodings: ALT selects SUB / SRA
    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [F7_W-1:0] f7;
        logic [F3_W-1:0] f3;
    } funct_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of the shared-ALU arbiter.
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req_x*/req_y*/req_f3_*/req_f7_* : requester 0/1 operands and funct fields
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_data/rsp_zero   : shared registered result and its zero flag
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [XLEN-1:0] req_x0;
    logic [XLEN-1:0] req_y0;
    logic [2:0]      req_f3_0;
    logic [6:0]      req_f7_0;
    logic [XLEN-1:0] req_x1;
    logic [XLEN-1:0] req_y1;
    logic [2:0]      req_f3_1;
    logic [6:0]      req_f7_1;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_zero;

    modport master (
        output req_valid, req_x0, req_y0, req_f3_0, req_f7_0,
               req_x1, req_y1, req_f3_1, req_f7_1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero
    );

    modport slave (
        input  req_valid, req_x0, req_y0, req_f3_0, req_f7_0,
               req_x1, req_y1, req_f3_1, req_f7_1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   valid      : request valid per requester
//   last_grant : id of the requester served most recently
//   grant_c    : one-hot grant (combinational), zero when nothing is valid
module alu_share_arbiter_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant_c
);
    // Under contention the requester that was not served last wins
    always_comb begin
        grant_c = 2'b00;
        unique case (valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between the integer execute path
// (requester 0) and the address/branch-compare unit (requester 1).
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : request/response handshakes and payloads
//   alu_x/alu_y     : registered operands to the ALU
//   alu_funct3/7    : registered funct fields to the ALU (funct3 bit 3 = 0)
//   alu_out         : ALU result, captured during EXEC
//   busy            : high while an operation is in EXEC or RESP
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus,
    output logic [XLEN-1:0]     alu_x,
    output logic [XLEN-1:0]     alu_y,
    output logic [F3_ALU_W-1:0] alu_funct3,
    output logic [F7_W-1:0]     alu_funct7,
    input  logic [XLEN-1:0]     alu_out,
    output logic                busy
);

    state_e            state_q;
    state_e            state_d;
    logic              last_grant_q;
    logic              gid_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              rsp_zero_q;
    logic [NREQ-1:0]   rsp_valid_q;

    logic [NREQ-1:0]   grant_c;
    logic [NREQ-1:0]   req_ready_c;
    logic              load_c;
    logic              done_c;
    logic [XLEN-1:0]   sel_x_c;
    logic [XLEN-1:0]   sel_y_c;
    funct_t            sel_funct_c;

    alu_share_arbiter_rr_arb2 u_arb (
        .valid      (bus.req_valid),
        .last_grant (last_grant_q),
        .grant_c    (grant_c)
    );

    // Operand/funct mux from the granted requester
    always_comb begin
        sel_x_c        = bus.req_x0;
        sel_y_c        = bus.req_y0;
        sel_funct_c.f3 = bus.req_f3_0;
        sel_funct_c.f7 = bus.req_f7_0;
        if (grant_c[1]) begin
            sel_x_c        = bus.req_x1;
            sel_y_c        = bus.req_y1;
            sel_funct_c.f3 = bus.req_f3_1;
            sel_funct_c.f7 = bus.req_f7_1;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d     = state_q;
        req_ready_c = '0;
        load_c      = 1'b0;
        done_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_c = grant_c;
                if (|grant_c) begin
                    load_c  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                // Only the owning requester's rsp_ready completes the response
                if (bus.rsp_ready[gid_q]) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            alu_x        <= '0;
            alu_y        <= '0;
            alu_funct3   <= '0;
            alu_funct7   <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_valid_q  <= '0;
            busy         <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            if (load_c) begin
                gid_q      <= grant_c[1];
                alu_x      <= sel_x_c;
                alu_y      <= sel_y_c;
                alu_funct3 <= F3_ALU_W'(sel_funct_c.f3);
                alu_funct7 <= sel_funct_c.f7;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= alu_out;
                rsp_zero_q <= (alu_out == '0);
            end
            if (done_c) begin
                last_grant_q <= gid_q;
            end
            rsp_valid_q <= '0;
            if (state_d == RESP) begin
                rsp_valid_q[gid_q] <= 1'b1;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned FW   = 2 * XLEN + 10;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [XLEN-1:0] alu_x;
    logic [XLEN-1:0] alu_y;
    logic [3:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_out;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arbiter_if #(.XLEN(XLEN)) bus ();

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural RV32 ALU standing in for the parent's instance
    function automatic logic [XLEN-1:0] alu_ref(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                                input logic [3:0] f3, input logic [6:0] f7);
        logic [4:0] sh;
        sh = y[4:0];
        if (f3[3]) return '0;
        case (f3[2:0])
            F3_ADD_SUB: return (f7 == F7_ALT) ? x - y : x + y;
            F3_SLL:     return x << sh;
            F3_SLT:     return XLEN'($signed(x) < $signed(y));
            F3_SLTU:    return XLEN'(x < y);
            F3_XOR:     return x ^ y;
            F3_SRL_SRA: return (f7 == F7_ALT) ? XLEN'($signed(x) >>> sh) : x >> sh;
            F3_OR:      return x | y;
            default:    return x & y;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_x, alu_y, alu_funct3, alu_funct7);

    // Requesters must hold fields stable while waiting to be accepted
    initial begin
        logic [1:0]    wait_q;
        logic [FW-1:0] f0_q;
        logic [FW-1:0] f1_q;
        wait_q = 2'b00;
        f0_q   = '0;
        f1_q   = '0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (wait_q[0] && bus.req_valid[0]) begin
                    n_vec++;
                    if ({bus.req_x0, bus.req_y0, bus.req_f3_0, bus.req_f7_0} !== f0_q) begin
                        n_err++;
                        $display("FAIL stable_req0: got %h want %h", {bus.req_x0, bus.req_y0, bus.req_f3_0, bus.req_f7_0}, f0_q);
                    end
                end
                if (wait_q[1] && bus.req_valid[1]) begin
                    n_vec++;
                    if ({bus.req_x1, bus.req_y1, bus.req_f3_1, bus.req_f7_1} !== f1_q) begin
                        n_err++;
                        $display("FAIL stable_req1: got %h want %h", {bus.req_x1, bus.req_y1, bus.req_f3_1, bus.req_f7_1}, f1_q);
                    end
                end
            end
            wait_q = rst_n ? (bus.req_valid & ~bus.req_ready) : 2'b00;
            f0_q   = {bus.req_x0, bus.req_y0, bus.req_f3_0, bus.req_f7_0};
            f1_q   = {bus.req_x1, bus.req_y1, bus.req_f3_1, bus.req_f7_1};
        end
    end

    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.req_x0 = '0; bus.req_y0 = '0; bus.req_f3_0 = '0; bus.req_f7_0 = '0;
        bus.req_x1 = '0; bus.req_y1 = '0; bus.req_f3_1 = '0; bus.req_f7_1 = '0;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #2;
        n_vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_zero, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.req_ready, bus.rsp_valid, bus.rsp_zero, busy});
        end
        n_vec++;
        if ({alu_x, alu_y, alu_funct3, alu_funct7, bus.rsp_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got x=%h y=%h f3=%h f7=%h d=%h want all 0", alu_x, alu_y, alu_funct3, alu_funct7, bus.rsp_data);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        bus.req_valid = 2'b01;
        bus.req_x0 = 32'd5; bus.req_y0 = 32'd7; bus.req_f3_0 = F3_ADD_SUB; bus.req_f7_0 = F7_BASE;
        bus.rsp_ready = 2'b01;
        #1;
        n_vec++;
        if (bus.req_ready !== 2'b01) begin
            n_err++; $display("FAIL single_ready: got %b want 01", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        #1;
        n_vec++;
        if ({alu_x, alu_y, busy, bus.rsp_valid} !== {32'd5, 32'd7, 1'b1, 2'b00}) begin
            n_err++; $display("FAIL single_exec: got x=%0d y=%0d busy=%b rv=%b want 5 7 1 00", alu_x, alu_y, busy, bus.rsp_valid);
        end
        @(posedge clk); #2;
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero} !== {2'b01, 32'd12, 1'b0}) begin
            n_err++; $display("FAIL single_resp: got rv=%b d=%0d z=%b want 01 12 0", bus.rsp_valid, bus.rsp_data, bus.rsp_zero);
        end
        @(posedge clk); #2;
        n_vec++;
        if ({busy, bus.rsp_valid} !== 3'b000) begin
            n_err++; $display("FAIL single_done: got busy=%b rv=%b want 0 00", busy, bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        do_reset();
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        bus.req_x0 = 32'd1; bus.req_y0 = 32'd1; bus.req_f3_0 = F3_ADD_SUB; bus.req_f7_0 = F7_BASE;
        bus.req_x1 = 32'd9; bus.req_y1 = 32'd9; bus.req_f3_1 = F3_ADD_SUB; bus.req_f7_1 = F7_ALT;
        bus.rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
            for (int c = 0; c < 4 && bus.req_ready == 2'b00; c++) begin
                @(posedge clk); #2;
            end
            n_vec++;
            if (bus.req_ready !== exp) begin
                n_err++; $display("FAIL contention_grant%0d: got %b want %b", k, bus.req_ready, exp);
            end
            @(posedge clk); #2;
            @(posedge clk); #2;
            n_vec++;
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero} !== {exp, (k % 2 == 1) ? 32'd0 : 32'd2, k % 2 == 1}) begin
                n_err++; $display("FAIL contention_resp%0d: got rv=%b d=%0d z=%b want %b %0d %0d",
                                  k, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, exp, (k % 2 == 1) ? 0 : 2, k % 2);
            end
            if (k == 3) bus.req_valid = 2'b00;
            @(posedge clk); #2;
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        bus.req_x1 = 32'd1; bus.req_y1 = 32'd2; bus.req_f3_1 = F3_SLTU; bus.req_f7_1 = F7_BASE;
        bus.rsp_ready = 2'b00;
        #1;
        n_vec++;
        if (bus.req_ready !== 2'b10) begin
            n_err++; $display("FAIL bp_grant: got %b want 10", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b01;
        bus.req_x0 = 32'd3; bus.req_y0 = 32'd4; bus.req_f3_0 = F3_ADD_SUB; bus.req_f7_0 = F7_BASE;
        @(posedge clk); #2;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.req_ready} !== {2'b10, 32'd1, 1'b0, 2'b00}) begin
                n_err++; $display("FAIL bp_hold%0d: got rv=%b d=%0d z=%b rr=%b want 10 1 0 00",
                                  i, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.req_ready);
            end
            @(posedge clk); #2;
        end
        bus.rsp_ready = 2'b10;
        #1;
        n_vec++;
        if (bus.rsp_valid !== 2'b10) begin
            n_err++; $display("FAIL bp_last: got %b want 10", bus.rsp_valid);
        end
        @(posedge clk); #2;
        n_vec++;
        if ({bus.rsp_valid, bus.req_ready, busy} !== {2'b00, 2'b01, 1'b0}) begin
            n_err++; $display("FAIL bp_release: got rv=%b rr=%b busy=%b want 00 01 0", bus.rsp_valid, bus.req_ready, busy);
        end
        bus.req_valid = 2'b00;
        @(posedge clk); #2;
        n_vec++;
        if ({busy, bus.req_ready} !== 3'b000) begin
            n_err++; $display("FAIL drop_noaction: got busy=%b rr=%b want 0 00", busy, bus.req_ready);
        end
    endtask

    task automatic test_wrong_owner();
        @(posedge clk); #1;
        bus.req_valid = 2'b01;
        bus.req_x0 = 32'd2; bus.req_y0 = 32'd3; bus.req_f3_0 = F3_ADD_SUB; bus.req_f7_0 = F7_BASE;
        bus.rsp_ready = 2'b10;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({bus.rsp_valid, busy, bus.rsp_data} !== {2'b01, 1'b1, 32'd5}) begin
                n_err++; $display("FAIL wrong_owner%0d: got rv=%b busy=%b d=%0d want 01 1 5", i, bus.rsp_valid, busy, bus.rsp_data);
            end
            @(posedge clk); #2;
        end
        bus.rsp_ready = 2'b01;
        @(posedge clk); #2;
        n_vec++;
        if ({busy, bus.rsp_valid} !== 3'b000) begin
            n_err++; $display("FAIL wrong_owner_done: got busy=%b rv=%b want 0 00", busy, bus.rsp_valid);
        end
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        bus.req_x1 = 32'hFF; bus.req_y1 = 32'h0F; bus.req_f3_1 = F3_XOR; bus.req_f7_1 = F7_BASE;
        bus.rsp_ready = 2'b11;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({alu_x, bus.rsp_data, busy, bus.rsp_valid, bus.req_ready} !== '0) begin
            n_err++; $display("FAIL midop_reset: got x=%h d=%h busy=%b rv=%b rr=%b want all 0",
                              alu_x, bus.rsp_data, busy, bus.rsp_valid, bus.req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_x0 = 32'd10; bus.req_y0 = 32'd20; bus.req_f3_0 = F3_ADD_SUB; bus.req_f7_0 = F7_BASE;
        bus.req_x1 = 32'd1;  bus.req_y1 = 32'd1;  bus.req_f3_1 = F3_ADD_SUB; bus.req_f7_1 = F7_BASE;
        #1;
        n_vec++;
        if (bus.req_ready !== 2'b01) begin
            n_err++; $display("FAIL midop_priority: got %b want 01", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_data} !== {2'b01, 32'd30}) begin
            n_err++; $display("FAIL midop_resp: got rv=%b d=%0d want 01 30", bus.rsp_valid, bus.rsp_data);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_funct_map();
        @(posedge clk); #1;
        bus.req_valid = 2'b01;
        bus.req_x0 = 32'h8000_0000; bus.req_y0 = 32'd4; bus.req_f3_0 = F3_SRL_SRA; bus.req_f7_0 = F7_ALT;
        bus.rsp_ready = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        #1;
        n_vec++;
        if ({alu_funct3, alu_funct7, alu_x, alu_y} !== {4'b0101, 7'b0100000, 32'h8000_0000, 32'd4}) begin
            n_err++; $display("FAIL funct_exec: got f3=%b f7=%b x=%h y=%h want 0101 0100000 80000000 4",
                              alu_funct3, alu_funct7, alu_x, alu_y);
        end
        @(posedge clk); #2;
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero} !== {2'b01, 32'hF800_0000, 1'b0}) begin
            n_err++; $display("FAIL funct_resp: got rv=%b d=%h z=%b want 01 f8000000 0", bus.rsp_valid, bus.rsp_data, bus.rsp_zero);
        end
        @(posedge clk); #2;
    endtask

    // Randomized traffic against a transaction-level model: one outstanding op,
    // its age in cycles since acceptance, and the id of the last completed op
    task automatic test_random();
        logic [XLEN-1:0] px [2];
        logic [XLEN-1:0] py [2];
        logic [2:0]      pf3 [2];
        logic [6:0]      pf7 [2];
        logic [1:0]      pend;
        logic            have_op;
        logic            gid;
        logic            last;
        int              age;
        logic [XLEN-1:0] ox, oy, exp_d;
        logic [2:0]      of3;
        logic [6:0]      of7;
        logic [1:0]      exp_rr, exp_rv;
        pend = 2'b00; have_op = 1'b0; gid = 1'b0; last = 1'b1; age = 0;
        ox = '0; oy = '0; of3 = '0; of7 = '0;
        for (int i = 0; i < 2; i++) begin
            px[i] = '0; py[i] = '0; pf3[i] = '0; pf7[i] = '0;
        end
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    px[i]   = $urandom;
                    py[i]   = ($urandom_range(3) == 0) ? px[i] : $urandom;
                    pf3[i]  = 3'($urandom_range(7));
                    pf7[i]  = ((pf3[i] == F3_ADD_SUB || pf3[i] == F3_SRL_SRA) && $urandom_range(1) == 1) ? F7_ALT : F7_BASE;
                end
            end
            bus.req_valid = pend;
            bus.req_x0 = px[0]; bus.req_y0 = py[0]; bus.req_f3_0 = pf3[0]; bus.req_f7_0 = pf7[0];
            bus.req_x1 = px[1]; bus.req_y1 = py[1]; bus.req_f3_1 = pf3[1]; bus.req_f7_1 = pf7[1];
            bus.rsp_ready = 2'($urandom_range(3));
            #1;
            exp_rr = 2'b00;
            if (!have_op) exp_rr = (pend == 2'b11) ? (last ? 2'b01 : 2'b10) : pend;
            exp_rv = (have_op && age >= 2) ? (gid ? 2'b10 : 2'b01) : 2'b00;
            n_vec++;
            if ({bus.req_ready, bus.rsp_valid, busy} !== {exp_rr, exp_rv, have_op}) begin
                n_err++; $display("FAIL rand_ctrl c%0d: got rr=%b rv=%b busy=%b want %b %b %b",
                                  cyc, bus.req_ready, bus.rsp_valid, busy, exp_rr, exp_rv, have_op);
            end
            if (have_op && age == 1) begin
                n_vec++;
                if ({alu_x, alu_y, alu_funct3, alu_funct7} !== {ox, oy, 1'b0, of3, of7}) begin
                    n_err++; $display("FAIL rand_exec c%0d: got x=%h y=%h f3=%h f7=%h want %h %h %h %h",
                                      cyc, alu_x, alu_y, alu_funct3, alu_funct7, ox, oy, of3, of7);
                end
            end
            if (have_op && age >= 2) begin
                exp_d = alu_ref(ox, oy, {1'b0, of3}, of7);
                n_vec++;
                if ({bus.rsp_data, bus.rsp_zero} !== {exp_d, exp_d == '0}) begin
                    n_err++; $display("FAIL rand_resp c%0d: got d=%h z=%b want %h %b",
                                      cyc, bus.rsp_data, bus.rsp_zero, exp_d, exp_d == '0);
                end
            end
            if (!have_op) begin
                if (exp_rr != 2'b00) begin
                    gid = exp_rr[1];
                    have_op = 1'b1; age = 1;
                    ox = px[gid]; oy = py[gid]; of3 = pf3[gid]; of7 = pf7[gid];
                    pend[gid] = 1'b0;
                end
            end else if (age >= 2 && bus.rsp_ready[gid]) begin
                have_op = 1'b0;
                last = gid;
            end else begin
                age++;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrong_owner();
        test_reset_midop();
        test_funct_map();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters: requester 0 is the integer execute path, requester 1 is the address/branch-compare unit.
- Accepts one operation at a time through a valid/ready handshake and registers the operands into the ALU.
- Captures the result and zero flag, then holds them until the owning requester accepts the response.
- Round-robin arbitration prevents starvation under continuous contention.

Parameters:
- XLEN, 32, operand/result width; must match ALU width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accept.
- req_x0, req_y0  in  XLEN  requester 0 operands.
- req_f3_0  in  3  requester 0 funct3.
- req_f7_0  in  7  requester 0 funct7.
- req_x1, req_y1, req_f3_1, req_f7_1  in  XLEN/XLEN/3/7  requester 1 equivalents.
- alu_x, alu_y  out  XLEN  operands to ALU.
- alu_funct3  out  4  to ALU; bit 3 always 0.
- alu_funct7  out  7  to ALU.
- alu_out  in  XLEN  ALU result.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  XLEN  registered result, shared by both requesters.
- rsp_zero  out  1  1 when rsp_data == 0.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, last_grant=1.
  - Operand/funct registers, rsp_data and rsp_zero = 0.
  - req_ready=0, rsp_valid=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and high only for the granted requester.
  - Grant rule:
    - Only one requester valid: it wins.
    - Both valid: the requester != last_grant wins.
    - Neither valid: req_ready=0.
  - On handshake: latch x, y, funct3 (zero-extended to 4 bits), funct7 and the grant id; go to EXEC.
- EXEC (exactly one cycle):
  - alu_* outputs reflect the latched registers.
  - At the clock edge: rsp_data <= alu_out, rsp_zero <= (alu_out == 0); go to RESP.
- RESP:
  - rsp_valid[gid]=1; the other bit stays 0.
  - rsp_data/rsp_zero are held stable until rsp_ready[gid]=1.
  - On that edge: last_grant <= gid; go to IDLE.
  - rsp_ready on the non-owner bit is ignored.
- Latency and throughput:
  - Request accepted in cycle N → rsp_valid high in cycle N+2 at the earliest.
  - Minimum 3 cycles per operation; no new request accepted during EXEC/RESP (req_ready=0).
- alu_* outputs are driven from registers at all times (0 after reset), so the ALU input never glitches from requester-side changes.
- Simultaneous events:
  - Both valid in IDLE → round-robin as above.
  - req_valid dropped while waiting unaccepted → no action.
  - Requesters must hold request fields stable while req_valid=1 and not accepted; a bench assertion checks this.
- rsp_ready held high ahead of time → response consumed in the first RESP cycle.
- Reset asserted mid-operation → the operation is dropped, no response is produced, state returns to IDLE, and requester 0 has priority afterwards.
- No internal arithmetic: the block only moves data. rsp_zero is the sole derived value, full XLEN-wide compare.

Decomposition:
- Shared package (alu_pkg):
  - funct3 constants: ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND=111.
  - funct7 constants: F7_BASE=0000000, F7_ALT=0100000.
  - FSM state enum: IDLE/EXEC/RESP.
- One natural sub-module: rr_arb2, the 2-way round-robin grant logic (inputs valid[1:0], last_grant; output grant one-hot).
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Single op, requester 0: x=5, y=7, f3=000, f7=0, rsp_ready=1 → req_ready[0] high in cycle 0, alu_x=5 in cycle 1, rsp_valid=01 and rsp_data=12, rsp_zero=0 in cycle 2, busy low in cycle 3.
- Contention: both valid continuously; r0 ADD 1+1, r1 SUB 9-9 → grants in order r0, r1, r0, r1; r1 responses show rsp_data=0 and rsp_zero=1.
- Backpressure: r1 SLTU x=1, y=2 with rsp_ready=0 for 5 cycles → rsp_valid=10 held, rsp_data=1 stable, req_ready=00 throughout; completes on the cycle rsp_ready[1] rises.
- Wrong-owner ready: response owned by r0 while only rsp_ready[1]=1 → no handshake, state stays RESP.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 asynchronously; after release, both valid → r0 granted first.
- funct mapping: r0 f3=101, f7=0100000, x=0x80000000, y=4 → alu_funct3=0101, alu_funct7=0100000 presented during EXEC; rsp_data equals the ALU model output.
